// File: rtl/cache_trace_pkg.sv
// Shared types and ASCII constants for the trace-file line parser.
`timescale 1ns/1ps
package cache_trace_pkg;

    typedef enum logic [3:0] {
        READ   = 4'd0,
        WRITE  = 4'd1,
        IFETCH = 4'd2,
        INVAL  = 4'd3,
        SNOOP  = 4'd4,
        CLEAR  = 4'd8,
        PRINT  = 4'd9
    } cmd_e;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;

    typedef enum logic [2:0] {
        S_LEAD,
        S_CMD,
        S_SEP,
        S_ADDR,
        S_TAIL,
        S_EMIT,
        S_SKIP
    } state_e;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier: whitespace / line-feed / decimal / hex flags and the
// hex nibble value of an ASCII character.
`timescale 1ns/1ps
module ascii_char_class
    import cache_trace_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_ws,
    output logic       is_lf,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic [7:0] folded;
    logic       is_alpha;

    always_comb begin
        is_ws    = (char_in == ASCII_SP) || (char_in == ASCII_TAB) || (char_in == ASCII_CR);
        is_lf    = (char_in == ASCII_LF);
        is_dec   = (char_in >= 8'h30) && (char_in <= 8'h39);
        // Setting bit 5 maps 'A'-'F' onto 'a'-'f' and leaves no other char in that range.
        folded   = char_in | 8'h20;
        is_alpha = (folded >= 8'h61) && (folded <= 8'h66);
        is_hex   = is_dec || is_alpha;
        nibble   = 4'h0;
        if (is_dec) begin
            nibble = char_in[3:0];
        end else if (is_alpha) begin
            nibble = folded[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/trace_line_parser.sv
// Parses "<cmd> <hexaddr>" trace lines from a byte stream into command/address
// words; malformed lines are flagged, counted and skipped up to the next LF.
`timescale 1ns/1ps
module trace_line_parser
    import cache_trace_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter int          CNT_W          = 16,
    parameter logic [15:0] VALID_CMD_MASK = 16'h031F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [3:0]        cmd_out,
    output logic [ADDR_W-1:0] hex_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parse_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  line_count
);

    localparam int                MAX_DIG   = ADDR_W / 4;
    localparam int                DIG_W     = $clog2(MAX_DIG + 1);
    localparam logic [DIG_W-1:0]  MAX_DIG_C = DIG_W'(MAX_DIG);

    state_e              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic                perr_q;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
    logic                err_hit;
    logic                line_inc;

    logic       is_ws, is_lf, is_dec, is_hex;
    logic [3:0] nibble;

    ascii_char_class u_class (
        .char_in (char_in),
        .is_ws   (is_ws),
        .is_lf   (is_lf),
        .is_dec  (is_dec),
        .is_hex  (is_hex),
        .nibble  (nibble)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        dig_d      = dig_q;
        err_hit    = 1'b0;
        line_inc   = 1'b0;
        char_ready = (state_q != S_EMIT);

        if (char_valid && char_ready) begin
            case (state_q)
                S_LEAD: begin
                    if (is_dec && VALID_CMD_MASK[nibble]) begin
                        cmd_d   = nibble;
                        state_d = S_CMD;
                    end else if (!(is_ws || is_lf)) begin
                        err_hit = 1'b1;
                    end
                end
                S_CMD: begin
                    if (is_ws) state_d = S_SEP;
                    else       err_hit = 1'b1;
                end
                S_SEP: begin
                    if (is_hex) begin
                        addr_d  = ADDR_W'(nibble);
                        dig_d   = DIG_W'(1);
                        state_d = S_ADDR;
                    end else if (!is_ws) begin
                        err_hit = 1'b1;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        if (dig_q < MAX_DIG_C) begin
                            addr_d = {addr_q[ADDR_W-5:0], nibble};
                            dig_d  = dig_q + DIG_W'(1);
                        end else begin
                            err_hit = 1'b1;
                        end
                    end else if (is_ws) begin
                        state_d = S_TAIL;
                    end else if (is_lf) begin
                        state_d = S_EMIT;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                S_TAIL: begin
                    if (is_lf)       state_d = S_EMIT;
                    else if (!is_ws) err_hit = 1'b1;
                end
                S_SKIP: begin
                    if (is_lf) state_d = S_LEAD;
                end
                default: ;
            endcase
            // An offending LF already ends the line, so there is nothing left to skip.
            if (err_hit) state_d = is_lf ? S_LEAD : S_SKIP;
        end

        if ((state_q == S_EMIT) && out_ready) begin
            state_d  = S_LEAD;
            line_inc = 1'b1;
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        line_cnt_d = line_cnt_q;
        if (err_hit && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + CNT_W'(1);
        if (line_inc && (line_cnt_q != {CNT_W{1'b1}}))
            line_cnt_d = line_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEAD;
            cmd_q      <= 4'h0;
            addr_q     <= '0;
            dig_q      <= '0;
            perr_q     <= 1'b0;
            err_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            dig_q      <= dig_d;
            perr_q     <= err_hit;
            err_cnt_q  <= err_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign cmd_out    = cmd_q;
    assign hex_out    = addr_q;
    assign out_valid  = (state_q == S_EMIT);
    assign parse_err  = perr_q;
    assign err_count  = err_cnt_q;
    assign line_count = line_cnt_q;

endmodule

// File: tb/tb_trace_line_parser.sv
// Self-checking bench for trace_line_parser: directed scenarios plus randomized
// trace lines checked against a line-level reference model.
`timescale 1ns/1ps
module tb_trace_line_parser;

    localparam int          ADDR_W = 32;
    localparam int          CNT_W  = 16;
    localparam logic [15:0] MASK   = 16'h031F;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } out_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        char_in = 8'h00;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic [3:0]        cmd_out;
    logic [ADDR_W-1:0] hex_out;
    logic              out_valid;
    logic              out_ready;
    logic              parse_err;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  line_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t got_q[$];
    out_t exp_q[$];
    int   exp_lines = 0;
    int   exp_errs  = 0;
    bit   rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_ready = 1'b1;
    bit   idle_rand = 1'b0;

    always #5 clk = ~clk;

    assign out_ready = rdy_rand ? rnd_ready : rdy_force;

    trace_line_parser #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .VALID_CMD_MASK(MASK)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .cmd_out    (cmd_out),
        .hex_out    (hex_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parse_err  (parse_err),
        .err_count  (err_count),
        .line_count (line_count)
    );

    initial forever begin
        @(posedge clk); #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({cmd_out, hex_out});
    end

    // ---------------- reference model (whole-line rules) ----------------
    function automatic bit f_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0D);
    endfunction

    function automatic bit f_dec(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic bit f_hex(input logic [7:0] c);
        return f_dec(c) || ((c >= "a") && (c <= "f")) || ((c >= "A") && (c <= "F"));
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (f_dec(c)) return int'(c) - 48;
        if (c >= "a") return int'(c) - 97 + 10;
        return int'(c) - 65 + 10;
    endfunction

    // kind: 0 blank, 1 emitted, 2 malformed (errpos = index of offending char)
    function automatic void model_line(input bq_t q, output int kind, output logic [3:0] cmd,
                                       output logic [31:0] addr, output int errpos);
        int i = 0;
        int n = 0;
        int d;
        kind = 2; cmd = 4'h0; addr = 32'h0; errpos = -1;
        while (f_ws(q[i])) i++;
        if (q[i] == 8'h0A) begin kind = 0; return; end
        d = int'(q[i]) - 48;
        if (!(f_dec(q[i]) && MASK[d])) begin errpos = i; return; end
        cmd = 4'(d);
        i++;
        if (!f_ws(q[i])) begin errpos = i; return; end
        i++;
        while (f_ws(q[i])) i++;
        if (!f_hex(q[i])) begin errpos = i; return; end
        while (f_hex(q[i])) begin
            if (n == 8) begin errpos = i; return; end
            addr = addr * 16 + 32'(hexval(q[i]));
            n++;
            i++;
        end
        while (f_ws(q[i])) i++;
        if (q[i] != 8'h0A) begin errpos = i; return; end
        kind = 1;
    endfunction

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic model_expect(input bq_t q, output int errpos);
        int kind; logic [3:0] c; logic [31:0] a;
        model_line(q, kind, c, a, errpos);
        if (kind == 1) begin exp_q.push_back({c, a}); exp_lines++; end
        if (kind == 2) exp_errs++;
    endtask

    // ---------------- drivers ----------------
    task automatic send_char(input logic [7:0] c, output bit perr);
        bit taken = 1'b0;
        int t = 0;
        if (idle_rand && ($urandom_range(0, 3) == 0))
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        char_in = c;
        char_valid = 1'b1;
        while (!taken && t < 300) begin
            @(negedge clk); taken = char_ready;
            @(posedge clk); #1;
            t++;
        end
        char_valid = 1'b0;
        perr = parse_err;
        if (!taken) begin
            n_cmp++; n_bad++;
            $display("FAIL char_accept: char %02h not taken within %0d cycles", c, t);
        end
    endtask

    task automatic send_q(input bq_t q, output int errpos);
        bit perr;
        errpos = -1;
        for (int i = 0; i < q.size(); i++) begin
            send_char(q[i], perr);
            if (perr && errpos < 0) errpos = i;
        end
    endtask

    task automatic run_line(input string name, input bq_t q);
        int e_exp, e_got;
        model_expect(q, e_exp);
        send_q(q, e_got);
        n_cmp++;
        if (e_got !== e_exp) begin
            n_bad++;
            $display("FAIL %s errpos: got %0d want %0d", name, e_got, e_exp);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (out_valid && t < 500) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s drain: out_valid stuck after %0d cycles", name, t);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL %s out_count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s out[%0d]: got cmd=%0h hex=%08h want cmd=%0h hex=%08h", name, i,
                         got_q[i].cmd, got_q[i].addr, exp_q[i].cmd, exp_q[i].addr);
            end
        end
        n_cmp++;
        if (line_count !== CNT_W'(exp_lines)) begin
            n_bad++; $display("FAIL %s line_count: got %0d want %0d", name, line_count, exp_lines);
        end
        n_cmp++;
        if (err_count !== CNT_W'(exp_errs)) begin
            n_bad++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, exp_errs);
        end
        $display("%s: %0d outputs, line_count=%0d err_count=%0d", name, got_q.size(), line_count, err_count);
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if ({out_valid, parse_err, cmd_out, hex_out, err_count, line_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b err=%b cmd=%0h hex=%08h ec=%0d lc=%0d",
                     out_valid, parse_err, cmd_out, hex_out, err_count, line_count);
        end
        n_cmp++;
        if (char_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", char_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        run_line("basic", to_q("1 1A2B\n"));
        n_cmp++;
        if (out_valid !== 1'b1 || cmd_out !== 4'h1 || hex_out !== 32'h0000_1A2B) begin
            n_bad++;
            $display("FAIL basic_latency: valid=%b cmd=%0h hex=%08h want 1/1/00001a2b", out_valid, cmd_out, hex_out);
        end
        drain("test_basic");
    endtask

    task automatic test_ws_crlf();
        run_line("ws_crlf", to_q("  9 ffffffff\r\n"));
        drain("test_ws_crlf");
    endtask

    task automatic test_overflow();
        run_line("overflow", to_q("0 123456789\n"));
        run_line("after_ovf", to_q("2 10\n"));
        drain("test_overflow");
    endtask

    task automatic test_backpressure();
        int dummy;
        logic [3:0]  c0;
        logic [31:0] h0;
        rdy_force = 1'b0;
        model_expect(to_q("3 abc\n"), dummy);
        send_q(to_q("3 abc\n"), dummy);
        char_in = "1";
        char_valid = 1'b1;
        c0 = cmd_out;
        h0 = hex_out;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || char_ready !== 1'b0 || cmd_out !== c0 || hex_out !== h0 ||
                cmd_out !== 4'h3 || hex_out !== 32'hABC) begin
                n_bad++;
                $display("FAIL hold[%0d]: valid=%b ready=%b cmd=%0h hex=%08h want 1/0/3/00000abc",
                         k, out_valid, char_ready, cmd_out, hex_out);
            end
            @(posedge clk); #1;
        end
        rdy_force = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (char_ready !== 1'b0) begin
            n_bad++; $display("FAIL release_ready: got %b want 0 in accept cycle", char_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || char_ready !== 1'b1) begin
            n_bad++; $display("FAIL after_release: valid=%b ready=%b want 0/1", out_valid, char_ready);
        end
        @(posedge clk); #1;
        char_valid = 1'b0;
        model_expect(to_q("1 5\n"), dummy);
        send_q(to_q(" 5\n"), dummy);
        drain("test_backpressure");
    endtask

    task automatic test_errors();
        run_line("bad_cmd", to_q("7 100\n"));
        run_line("blank1", to_q("\n"));
        run_line("blank2", to_q("\n"));
        run_line("no_sep", to_q("4x3\n"));
        drain("test_errors");
    endtask

    task automatic test_reset_mid();
        int dummy;
        send_q(to_q("1 AB"), dummy);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_lines = 0;
        exp_errs = 0;
        n_cmp++;
        if (err_count !== '0 || line_count !== '0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_clear: ec=%0d lc=%0d valid=%b want 0/0/0", err_count, line_count, out_valid);
        end
        run_line("after_rst", to_q("3 C\n"));
        drain("test_reset_mid");
    endtask

    task automatic gen_line(output bq_t q);
        string ws = " \t\r";
        string hx = "0123456789abcdefABCDEF";
        string junk = "xZ-!g.";
        q.delete();
        if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 2)) q.push_back(ws[$urandom_range(0, 2)]);
            q.push_back(8'h0A);
            return;
        end
        repeat ($urandom_range(0, 2)) q.push_back(ws[$urandom_range(0, 2)]);
        q.push_back(8'(48 + $urandom_range(0, 9)));
        repeat (($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2)) q.push_back(ws[$urandom_range(0, 2)]);
        repeat ($urandom_range(1, 9)) q.push_back(hx[$urandom_range(0, 21)]);
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) q.push_back(ws[$urandom_range(0, 2)]);
        if ($urandom_range(0, 9) == 0) q[$urandom_range(0, q.size() - 1)] = junk[$urandom_range(0, 5)];
        q.push_back(8'h0A);
    endtask

    task automatic test_random();
        bq_t q;
        rdy_rand = 1'b1;
        idle_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            gen_line(q);
            run_line($sformatf("rand%0d", n), q);
        end
        rdy_rand = 1'b0;
        idle_rand = 1'b0;
        drain("test_random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ws_crlf();
        test_overflow();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
